// File: rtl/fsm_frame_arbiter_if.sv
// Framed-channel bus between the requesters and the packet arbiter:
// per-requester request/beat flags in, one-hot grant and the merged frame out.
interface fsm_frame_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] head_in;
    logic [NREQ-1:0] tail_in;
    logic [NREQ-1:0] valid_in;
    logic [NREQ-1:0] gnt;
    logic            head;
    logic            tail;
    logic            valid;
    logic            busy;
    logic            abort;
    logic            err;

    modport master (
        output req, head_in, tail_in, valid_in,
        input  gnt, head, tail, valid, busy, abort, err
    );

    modport slave (
        input  req, head_in, tail_in, valid_in,
        output gnt, head, tail, valid, busy, abort, err
    );
endinterface

// File: rtl/fsm_frame_arbiter.sv
// Round-robin whole-packet arbiter feeding one head/tail/valid framed channel;
// stalled or abandoned packets are force-closed with a one-cycle abort beat.
module fsm_frame_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    fsm_frame_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   last_winner;
    logic [IW-1:0]   w;
    logic [TW-1:0]   tcnt;
    logic            first_beat;
    logic [NREQ-1:0] gnt_p1;
    logic            head_p1;
    logic            tail_p1;
    logic            vld_p1;
    logic            abort_p1;
    logic            err_q;

    logic [IW-1:0]   pick;
    logic            beat_vld;
    logic            beat_head;
    logic            beat_tail;
    logic            req_w;
    logic            timed_out;

    // First set request strictly after 'last', wrapping modulo NREQ.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   last);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = last;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!found && r[idx]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign pick      = rr_pick(bus.req, last_winner);
    assign beat_vld  = bus.valid_in[w];
    assign beat_head = bus.head_in[w] & beat_vld;
    assign beat_tail = bus.tail_in[w] & beat_vld;
    assign req_w     = bus.req[w];
    assign timed_out = (tcnt == TW'(TIMEOUT));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            last_winner <= IW'(NREQ - 1);
            w           <= '0;
            tcnt        <= '0;
            first_beat  <= 1'b0;
            gnt_p1      <= '0;
            head_p1     <= 1'b0;
            tail_p1     <= 1'b0;
            vld_p1      <= 1'b0;
            abort_p1    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            head_p1  <= 1'b0;
            tail_p1  <= 1'b0;
            vld_p1   <= 1'b0;
            abort_p1 <= 1'b0;
            case (state)
                // p0 -> p1: arbitrate and lock the winner for a whole packet
                IDLE: begin
                    gnt_p1 <= '0;
                    if (|bus.req) begin
                        w           <= pick;
                        last_winner <= pick;
                        gnt_p1      <= onehot(pick);
                        tcnt        <= '0;
                        first_beat  <= 1'b1;
                        state       <= XFER;
                    end
                end
                // p0 -> p1: forward the granted beat, watch for stall or drop
                XFER: begin
                    head_p1 <= beat_head;
                    tail_p1 <= beat_tail;
                    vld_p1  <= beat_vld;
                    if (beat_vld) begin
                        tcnt       <= '0;
                        first_beat <= 1'b0;
                        if (first_beat && !bus.head_in[w])
                            err_q <= 1'b1;
                    end else if (!timed_out) begin
                        tcnt <= tcnt + TW'(1);
                    end
                    // A tail beat wins over a simultaneous timeout or drop.
                    if (beat_tail) begin
                        gnt_p1 <= '0;
                        state  <= IDLE;
                    end else if (timed_out || !req_w) begin
                        gnt_p1   <= '0;
                        head_p1  <= 1'b0;
                        tail_p1  <= 1'b1;
                        vld_p1   <= 1'b1;
                        abort_p1 <= 1'b1;
                        state    <= ABORT;
                    end
                end
                ABORT: begin
                    gnt_p1 <= '0;
                    state  <= IDLE;
                end
                default: begin
                    gnt_p1 <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_p1;
    assign bus.head  = head_p1;
    assign bus.tail  = tail_p1;
    assign bus.valid = vld_p1;
    assign bus.busy  = (state == XFER);
    assign bus.abort = abort_p1;
    assign bus.err   = err_q;
endmodule
